iter_shift_unit: RTL
====================

Name: iter_shift_unit

Overview:
- Multi-cycle shift/rotate execution unit downstream of the datapath's Y register and bus.
- Consumes the operand latched in RY (A) and the shift amount on the bus (B) when the control step pulses start.
- Produces the result for the RZ register and returns the start/finished handshake the datapath waits on before its RZ-to-register-file step.
- Shifts STEP bit positions per clock, trading latency for a small shifter.

Parameters:
WIDTH  32  operand/result width; shift amount field is $clog2(WIDTH) bits (5 for 32)
STEP   1   maximum bit positions shifted per SHIFT cycle; legal range 1..WIDTH/2

Ports:
Clock     in   1      rising-edge clock
clear     in   1      synchronous active-low reset
start     in   1      request; sampled only in IDLE
op        in   3      000 shr, 001 shra, 010 shl, 011 ror, 100 rol, others pass-through
A         in   WIDTH  operand (from RY)
B         in   WIDTH  amount; only B[$clog2(WIDTH)-1:0] used, upper bits ignored
result    out  WIDTH  shifted value, to RZ
finished  out  1      one-cycle completion pulse
busy      out  1      high in SHIFT state

Behaviour:
- Reset: clear low at a rising edge -> state IDLE, result=0, finished=0, busy=0, internal count=0; overrides any in-flight operation and any start in the same cycle.
- States: IDLE, SHIFT.
- IDLE: finished=0 except for the single pulse cycle below.
  - If start=1 at an edge: latch acc<=A, opcode<=op, cnt<=B[4:0]; go to SHIFT.
  - result keeps its previous value until the first SHIFT update.
- SHIFT:
  - If cnt==0 at an edge: result<=acc, finished<=1 for exactly one cycle, go to IDLE.
  - Otherwise: k=min(cnt,STEP); acc shifted/rotated by k per opcode; cnt<=cnt-k.
- Opcode semantics:
  - shr fills with 0; shra fills with acc[WIDTH-1]; shl fills LSBs with 0.
  - ror/rol wrap bits around.
  - Undefined opcodes leave acc unchanged but still consume the count cycles.
- Latency: start sampled at edge k -> finished high during the cycle after edge k+1+ceil(n/STEP), where n=B[4:0].
  - n=0: finished after edge k+1, result=A.
  - STEP=1, n=31: 32 cycles.
- Result holding: result holds after finished until the next operation completes. It is never partially updated mid-operation; acc is internal.
- start while busy=1: ignored, with no effect on acc, cnt or opcode. start in the same cycle finished is high: accepted, since the state is IDLE.
- start held high continuously: a new operation begins on every return to IDLE. Control must deassert start within the finished cycle to avoid a repeat.
- A, B, op may change freely after the start edge.
- Amount modulo: shift amount is modulo WIDTH by construction; B=32 behaves as 0.

Optional Feature:
SHIFT_CARRY_EN
- Defined: adds output carry (1 bit), the last bit shifted or rotated out. Reset 0.
  - Updated together with result on completion; holds between operations.
  - n=0 or undefined opcode -> carry=0.
- Not defined: no carry port; no carry logic synthesized.

Test Plan:
- Reset, then shr: clear=0 for 2 cycles -> result=0, finished=0, busy=0. Then A=0x00000018, B=2, op=000, start 1 cycle, STEP=1 -> finished pulses exactly once, 3 edges after start edge; result=0x00000006.
- Signed shifts: shra A=0x80000000, B=4 -> 0xF8000000. shl A=0x0000000F, B=28 -> 0xF0000000. With STEP=4, shl completes 8 edges after start.
- Rotates: rol A=0x80000001, B=1 -> 0x00000003. ror A=0x00000001, B=1 -> 0x80000000; carry=1 when SHIFT_CARRY_EN is defined.
- Zero amount: B=0 (and B=0x20) with A=0x12345678 -> result=0x12345678 after 1-edge latency.
- Busy handling: second start (A=0xFFFFFFFF) asserted while busy -> ignored; first result unchanged. A start in the finished cycle is accepted and completes normally.
- Reset mid-operation: clear=0 during SHIFT of B=20 -> next edge shows result=0, busy=0, and finished never pulses. A subsequent shr 0x100 by 8 -> 0x1.

Source files
------------

// File: rtl/iter_shift_unit.sv
// Iterative shift/rotate unit: moves up to STEP bit positions per clock and
// publishes the result once. Define SHIFT_CARRY_EN to add the carry output.
module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] result,
  output logic             finished,
  output logic             busy
`ifdef SHIFT_CARRY_EN
  ,
  output logic             carry
`endif
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [2:0]       opcode;
  logic [SW-1:0]    cnt, k, wmk;

  // Amounts are modulo WIDTH, so the upper bits of B never matter.
  logic unused_b;
  assign unused_b = ^B[WIDTH-1:SW];

  always_ff @(posedge Clock) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start)      state_nxt = SHIFT;
      SHIFT:   if (cnt == '0)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT);
  end

  // One step of at most STEP positions; k is only meaningful while cnt != 0.
  always_comb begin
    k   = (cnt > STEP_W) ? STEP_W : cnt;
    wmk = SW'(WIDTH - int'(k));
    case (opcode)
      OP_SHR:  acc_nxt = acc >> k;
      OP_SHRA: acc_nxt = $signed(acc) >>> k;
      OP_SHL:  acc_nxt = acc << k;
      OP_ROR:  acc_nxt = (acc >> k) | (acc << wmk);
      OP_ROL:  acc_nxt = (acc << k) | (acc >> wmk);
      default: acc_nxt = acc;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!clear) begin
      acc      <= '0;
      opcode   <= '0;
      cnt      <= '0;
      result   <= '0;
      finished <= 1'b0;
    end else begin
      finished <= 1'b0;
      case (state)
        IDLE: if (start) begin
          acc    <= A;
          opcode <= op;
          cnt    <= B[SW-1:0];
        end
        SHIFT: if (cnt == '0) begin
          result   <= acc;
          finished <= 1'b1;
        end else begin
          acc <= acc_nxt;
          cnt <= cnt - k;
        end
        default: ;
      endcase
    end
  end

`ifdef SHIFT_CARRY_EN
  logic          out_bit, carry_acc;
  logic [SW-1:0] km1;

  // Bit leaving the word on this step: low end for right moves, high end for left.
  always_comb begin
    km1 = k - SW'(1);
    case (opcode)
      OP_SHR, OP_SHRA, OP_ROR: out_bit = acc[km1];
      OP_SHL, OP_ROL:          out_bit = acc[wmk];
      default:                 out_bit = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!clear) begin
      carry_acc <= 1'b0;
      carry     <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (start) carry_acc <= 1'b0;
        SHIFT: if (cnt == '0) carry <= carry_acc;
               else           carry_acc <= out_bit;
        default: ;
      endcase
    end
  end
`endif

endmodule
